// File: rtl/inst_encoder_if.sv
// Descriptor-in / instruction-word-out handshake bundle for inst_encoder.
// Also carries the flush request and the buffered word count.
interface inst_encoder_if #(
    parameter int CNT_W = 3
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [4:0]       op_i;
    logic [4:0]       rd_i;
    logic [4:0]       rs1_i;
    logic [4:0]       rs2_i;
    logic [31:0]      imm_i;
    logic             flush_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      inst_o;
    logic             err_o;
    logic [CNT_W-1:0] count_o;

    modport master (
        output in_valid_i, op_i, rd_i, rs1_i, rs2_i, imm_i,
        output flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, inst_o, err_o, count_o
    );

    modport slave (
        input  in_valid_i, op_i, rd_i, rs1_i, rs2_i, imm_i,
        input  flush_i, out_ready_i,
        output in_ready_o, out_valid_o, inst_o, err_o, count_o
    );
endinterface

// File: rtl/inst_encoder.sv
// Packs RV32I-subset descriptors into instruction words behind a small FIFO.
// Define INST_ENCODER_IMMCHK_EN to replace out-of-range immediates with NOP/err.
module inst_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    inst_encoder_if.slave bus
);
    localparam int          PW  = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
        OP_SLT, OP_ADDI, OP_SLTI, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI,
        OP_SRLI, OP_SRAI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JAL, OP_JALR
    } op_e;

    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        i_bad;
    logic        b_bad;
    logic        j_bad;
    logic        sh_bad;

    assign rd  = bus.rd_i;
    assign rs1 = bus.rs1_i;
    assign rs2 = bus.rs2_i;
    assign imm = bus.imm_i;

`ifdef INST_ENCODER_IMMCHK_EN
    logic signed [31:0] simm;
    assign simm   = $signed(imm);
    assign i_bad  = (simm < -32'sd2048) || (simm > 32'sd2047);
    assign b_bad  = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
    assign j_bad  = (simm < -32'sd1048576) || (simm > 32'sd1048574)
                  || imm[0];
    assign sh_bad = |imm[31:5];
`else
    logic unused_imm;
    assign unused_imm = ^imm[31:21];
    assign i_bad  = 1'b0;
    assign b_bad  = 1'b0;
    assign j_bad  = 1'b0;
    assign sh_bad = 1'b0;
`endif

    logic [2:0]  f3;
    logic        alt;
    logic        bad;
    logic        enc_err;
    logic [31:0] enc;

    always_comb begin
        f3 = 3'b000;
        case (bus.op_i)
            OP_SLL, OP_SLLI, OP_BNE:           f3 = 3'b001;
            OP_SLT, OP_SLTI, OP_LW, OP_SW:     f3 = 3'b010;
            OP_XOR, OP_XORI:                   f3 = 3'b100;
            OP_SRL, OP_SRA, OP_SRLI, OP_SRAI:  f3 = 3'b101;
            OP_OR, OP_ORI:                     f3 = 3'b110;
            OP_AND, OP_ANDI:                   f3 = 3'b111;
            default:                           f3 = 3'b000;
        endcase
    end

    assign alt = (bus.op_i == OP_SUB) || (bus.op_i == OP_SRA)
              || (bus.op_i == OP_SRAI);

    always_comb begin
        enc     = NOP;
        enc_err = 1'b0;
        bad     = 1'b0;
        case (bus.op_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SLL, OP_SRL, OP_SRA, OP_SLT:
                enc = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
            OP_ADDI, OP_SLTI, OP_XORI, OP_ORI, OP_ANDI: begin
                bad = i_bad;
                enc = {imm[11:0], rs1, f3, rd, 7'b0010011};
            end
            OP_SLLI, OP_SRLI, OP_SRAI: begin
                bad = sh_bad;
                enc = {1'b0, alt, 5'b0, imm[4:0], rs1, f3, rd, 7'b0010011};
            end
            OP_LW: begin
                bad = i_bad;
                enc = {imm[11:0], rs1, f3, rd, 7'b0000011};
            end
            OP_SW: begin
                bad = i_bad;
                enc = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
            end
            OP_BEQ, OP_BNE: begin
                bad = b_bad;
                enc = {imm[12], imm[10:5], rs2, rs1, f3,
                       imm[4:1], imm[11], 7'b1100011};
            end
            OP_JAL: begin
                bad = j_bad;
                enc = {imm[20], imm[10:1], imm[11], imm[19:12],
                       rd, 7'b1101111};
            end
            OP_JALR: begin
                bad = i_bad;
                enc = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            enc     = NOP;
            enc_err = 1'b1;
        end
    end

    logic [32:0]      mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [32:0]      head_q;
    logic [32:0]      head_nxt;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign push  = bus.in_valid_i && !full && !bus.flush_i;
    assign pop   = bus.out_ready_i && !empty && !bus.flush_i;

    assign rd_nxt  = pop ? rd_ptr + 1'b1 : rd_ptr;
    assign cnt_nxt = cnt + CNT_W'(push) - CNT_W'(pop);

    // Output register tracks the next head; a push into a slot that
    // becomes the head is forwarded since the array write lands later.
    always_comb begin
        head_nxt = mem[rd_nxt];
        if (cnt_nxt == '0)
            head_nxt = '0;
        else if (push && (wr_ptr == rd_nxt))
            head_nxt = {enc_err, enc};
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            head_q <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_nxt;
            cnt    <= cnt_nxt;
            head_q <= head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {enc_err, enc};
    end

    assign bus.in_ready_o  = !full;
    assign bus.out_valid_o = !empty;
    assign bus.inst_o      = head_q[31:0];
    assign bus.err_o       = head_q[32];
    assign bus.count_o     = cnt;
endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: expected {err,inst} queued on push,
// compared on pop.
module tb_inst_encoder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    inst_encoder_if #(.CNT_W(3)) bus ();

    inst_encoder #(.DEPTH(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    localparam logic [4:0] ADDI = 5'd9;
    localparam logic [4:0] SUB  = 5'd1;
    localparam logic [4:0] SLLI = 5'd14;
    localparam logic [4:0] LW   = 5'd17;
    localparam logic [4:0] SW   = 5'd18;
    localparam logic [4:0] BEQ  = 5'd19;
    localparam logic [4:0] BNE  = 5'd20;
    localparam logic [4:0] JAL  = 5'd21;
    localparam logic [4:0] JALR = 5'd22;
    localparam logic [32:0] NOP_ERR = {1'b1, 32'h0000_0013};

    logic [32:0] sb[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic idle();
        bus.in_valid_i = 1'b0;
        bus.op_i       = '0;
        bus.rd_i       = '0;
        bus.rs1_i      = '0;
        bus.rs2_i      = '0;
        bus.imm_i      = '0;
        bus.flush_i    = 1'b0;
    endtask

    task automatic drive(input logic [4:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        bus.in_valid_i = 1'b1;
        bus.op_i       = op;
        bus.rd_i       = rd;
        bus.rs1_i      = rs1;
        bus.rs2_i      = rs2;
        bus.imm_i      = imm;
    endtask

    // Advance one clock; records an accepted push and reports a pop.
    task automatic step(input logic [32:0] exp, output bit popped,
                        output logic [32:0] got);
        #1;
        popped = bus.out_valid_o && bus.out_ready_i
              && !bus.flush_i && !rst;
        got = {bus.err_o, bus.inst_o};
        if (rst || bus.flush_i)
            sb.delete();
        else if (bus.in_valid_i && bus.in_ready_o)
            sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [32:0] addi_word(logic [4:0] rd,
                                              logic [11:0] imm);
        return {1'b0, imm, 5'd0, 3'b000, rd, 7'h13};
    endfunction

    task automatic test_reset();
        idle();
        bus.out_ready_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_chk++;
        if ({bus.count_o, bus.out_valid_o, bus.in_ready_o,
             bus.err_o, bus.inst_o} !== {3'd0, 1'b0, 1'b1, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset cnt=%0d ov=%b ir=%b err=%b inst=%h",
                     bus.count_o, bus.out_valid_o, bus.in_ready_o,
                     bus.err_o, bus.inst_o);
        end
    endtask

    task automatic test_encoding();
        bit p;
        logic [32:0] g, e;
        bus.out_ready_i = 1'b1;
        drive(ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
        step({1'b0, 32'h0050_0093}, p, g);
        n_chk++;
        if (bus.out_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL latency out_valid=%b want 1", bus.out_valid_o);
        end
        drive(SUB, 5'd3, 5'd1, 5'd2, 32'd0);
        step({1'b0, 32'h4020_81B3}, p, g);
        if (p) begin
            n_chk++;
            e = sb.size() ? sb.pop_front() : 'x;
            if (g !== e) begin
                n_fail++;
                $display("FAIL enc_addi got=%h want=%h", g, e);
            end
        end
        idle();
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            step('0, p, g);
            if (p) begin
                n_chk++;
                e = sb.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL enc_sub got=%h want=%h", g, e);
                end
            end
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL enc_drain left=%0d want 0", sb.size());
        end
    endtask

    task automatic test_store_branch_jump();
        bit p;
        logic [32:0] g, e;
        bus.out_ready_i = 1'b0;
        drive(SW, 5'd0, 5'd1, 5'd2, 32'd8);
        step({1'b0, 32'h0020_A423}, p, g);
        drive(BNE, 5'd0, 5'd1, 5'd2, -32'sd4);
        step({1'b0, 32'hFE20_9EE3}, p, g);
        drive(JAL, 5'd1, 5'd0, 5'd0, 32'd2048);
        step({1'b0, 32'h0010_00EF}, p, g);
        idle();
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            step('0, p, g);
            if (p) begin
                n_chk++;
                e = sb.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL sbj got=%h want=%h", g, e);
                end
            end
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sbj_drain left=%0d want 0", sb.size());
        end
    endtask

    task automatic test_full();
        bit p;
        logic [32:0] g, e;
        bus.out_ready_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(ADDI, 5'd1, 5'd0, 5'd0, 32'(k));
            step(addi_word(5'd1, 12'(k)), p, g);
        end
        n_chk++;
        if (bus.count_o !== 3'd4 || bus.in_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full cnt=%0d ir=%b want 4/0",
                     bus.count_o, bus.in_ready_o);
        end
        drive(ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
        step(addi_word(5'd1, 12'd5), p, g);
        n_chk++;
        if (bus.count_o !== 3'd4) begin
            n_fail++;
            $display("FAIL full_hold cnt=%0d want 4", bus.count_o);
        end
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step(addi_word(5'd1, 12'd5), p, g);
            if (p) begin
                n_chk++;
                e = sb.size() ? sb.pop_front() : 'x;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL full_pop got=%h want=%h", g, e);
                end
            end
            n_chk++;
            if (bus.count_o !== 3'd3) begin
                n_fail++;
                $display("FAIL no_bypass cnt=%0d want 3", bus.count_o);
            end
        end
        idle();
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            step('0, p, g);
            if (p) begin
                n_chk++;
                e = sb.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL full_drain got=%h want=%h", g, e);
                end
            end
        end
        n_chk++;
        if (sb.size() != 0 || bus.out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_empty left=%0d ov=%b want 0/0",
                     sb.size(), bus.out_valid_o);
        end
    endtask

    task automatic test_flush();
        bit p;
        logic [32:0] g;
        bus.out_ready_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive(ADDI, 5'd2, 5'd0, 5'd0, 32'(k));
            step(addi_word(5'd2, 12'(k)), p, g);
        end
        n_chk++;
        if (bus.count_o !== 3'd3) begin
            n_fail++;
            $display("FAIL flush_pre cnt=%0d want 3", bus.count_o);
        end
        drive(ADDI, 5'd2, 5'd0, 5'd0, 32'd99);
        bus.flush_i = 1'b1;
        step('0, p, g);
        n_chk++;
        if (bus.count_o !== 3'd0 || bus.out_valid_o !== 1'b0
            || bus.in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush cnt=%0d ov=%b ir=%b want 0/0/1",
                     bus.count_o, bus.out_valid_o, bus.in_ready_o);
        end
        idle();
        step('0, p, g);
        n_chk++;
        if (bus.count_o !== 3'd0) begin
            n_fail++;
            $display("FAIL flush_drop cnt=%0d want 0", bus.count_o);
        end
    endtask

    task automatic test_illegal();
        bit p;
        logic [32:0] g, e;
        bus.out_ready_i = 1'b0;
        drive(5'd25, 5'd5, 5'd6, 5'd7, 32'd123);
        step(NOP_ERR, p, g);
        drive(JALR, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF);
        step({1'b0, 32'hFFF1_00E7}, p, g);
        drive(5'd31, 5'd1, 5'd1, 5'd1, 32'd0);
        step(NOP_ERR, p, g);
        drive(LW, 5'd2, 5'd1, 5'd0, 32'd2047);
        step({1'b0, 32'h7FF0_A103}, p, g);
        idle();
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            step('0, p, g);
            if (p) begin
                n_chk++;
                e = sb.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL illegal got=%h want=%h", g, e);
                end
            end
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL illegal_drain left=%0d want 0", sb.size());
        end
    endtask

    task automatic test_immediates();
        bit p;
        logic [32:0] g, e;
        bus.out_ready_i = 1'b0;
`ifdef INST_ENCODER_IMMCHK_EN
        drive(ADDI, 5'd1, 5'd0, 5'd0, 32'd4096);
        step(NOP_ERR, p, g);
        drive(SLLI, 5'd1, 5'd0, 5'd0, 32'd33);
        step(NOP_ERR, p, g);
        drive(BEQ, 5'd0, 5'd0, 5'd0, 32'd3);
        step(NOP_ERR, p, g);
`else
        drive(ADDI, 5'd1, 5'd0, 5'd0, 32'd4096);
        step({1'b0, 32'h0000_0093}, p, g);
        drive(SLLI, 5'd1, 5'd0, 5'd0, 32'd33);
        step({1'b0, 32'h0010_1093}, p, g);
        drive(BEQ, 5'd0, 5'd0, 5'd0, 32'd3);
        step({1'b0, 32'h0000_0163}, p, g);
`endif
        drive(ADDI, 5'd1, 5'd0, 5'd0, -32'sd2048);
        step({1'b0, 32'h8000_0093}, p, g);
        idle();
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            step('0, p, g);
            if (p) begin
                n_chk++;
                e = sb.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL imm got=%h want=%h", g, e);
                end
            end
        end
        bus.out_ready_i = 1'b0;
        drive(JAL, 5'd0, 5'd0, 5'd0, -32'sd1048576);
        step({1'b0, 32'h8000_006F}, p, g);
        idle();
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            step('0, p, g);
            if (p) begin
                n_chk++;
                e = sb.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL imm_jal got=%h want=%h", g, e);
                end
            end
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL imm_drain left=%0d want 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        bit p;
        logic [32:0] g;
        bus.out_ready_i = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            drive(ADDI, 5'd4, 5'd0, 5'd0, 32'(k));
            step(addi_word(5'd4, 12'(k)), p, g);
        end
        n_chk++;
        if (bus.count_o !== 3'd2) begin
            n_fail++;
            $display("FAIL rst_pre cnt=%0d want 2", bus.count_o);
        end
        idle();
        rst = 1'b1;
        step('0, p, g);
        rst = 1'b0;
        n_chk++;
        if (bus.count_o !== 3'd0 || bus.out_valid_o !== 1'b0
            || bus.in_ready_o !== 1'b1 || bus.inst_o !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid cnt=%0d ov=%b ir=%b inst=%h",
                     bus.count_o, bus.out_valid_o, bus.in_ready_o,
                     bus.inst_o);
        end
    endtask

    task automatic test_back_to_back();
        bit p;
        logic [32:0] g, e;
        logic [11:0] r;
        for (int c = 0; c < 60; c++) begin
            r = 12'($urandom);
            bus.out_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0)
                drive(ADDI, 5'(c), 5'd0, 5'd0, {{20{r[11]}}, r});
            else
                idle();
            step(addi_word(5'(c), r), p, g);
            if (p) begin
                n_chk++;
                e = sb.size() ? sb.pop_front() : 'x;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL b2b c=%0d got=%h want=%h", c, g, e);
                end
            end
            n_chk++;
            if (int'(bus.count_o) != sb.size()) begin
                n_fail++;
                $display("FAIL b2b_cnt c=%0d got=%0d want=%0d",
                         c, bus.count_o, sb.size());
            end
        end
        idle();
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            step('0, p, g);
            if (p) begin
                n_chk++;
                e = sb.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL b2b_drain got=%h want=%h", g, e);
                end
            end
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_left left=%0d want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_encoding();
        test_store_branch_jump();
        test_full();
        test_flush();
        test_illegal();
        test_immediates();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
